// File: rtl/vmem_fill_ctrl.sv
// Rectangle-fill engine and vmem write-port arbiter for the 240x240 3-bit video memory.
// CPU stores always win the write port; the engine writes one pixel per free cycle.
module vmem_fill_ctrl #(
   parameter int unsigned WIDTH  = 240,
   parameter int unsigned HEIGHT = 240
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cfg_we_i,
   input  logic [3:0]  cfg_addr_i,
   input  logic [31:0] cfg_wdata_i,
   output logic [31:0] cfg_rdata_o,
   input  logic        cpu_we_i,
   input  logic [15:0] cpu_waddr_i,
   input  logic [2:0]  cpu_wdata_i,
   output logic        vmem_we_o,
   output logic [15:0] vmem_waddr_o,
   output logic [2:0]  vmem_wdata_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [8:0] WIDTH_L  = 9'(WIDTH);
   localparam logic [8:0] HEIGHT_L = 9'(HEIGHT);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     state, state_nxt;
   logic [7:0] x0, y0, w, h, x, y;
   logic [2:0] color;
   logic       done_flag, err_flag;

   logic       sel_ctrl, start_req, abort_req;
   logic [8:0] x_end, y_end;
   logic [7:0] x_last, y_last;
   logic       params_ok, at_last;
   logic       fill_we, launch, reject, finish;
   logic       unused_bits;

   assign unused_bits = ^{cfg_wdata_i[31:16], cfg_addr_i[1:0]};

   assign sel_ctrl  = cfg_we_i && (cfg_addr_i[3:2] == 2'd0);
   assign start_req = sel_ctrl && cfg_wdata_i[0];
   assign abort_req = sel_ctrl && cfg_wdata_i[1];

   assign x_end     = {1'b0, x0} + {1'b0, w};
   assign y_end     = {1'b0, y0} + {1'b0, h};
   assign x_last    = x0 + w - 8'd1;
   assign y_last    = y0 + h - 8'd1;
   assign params_ok = (w != '0) && (h != '0) && (x_end <= WIDTH_L) && (y_end <= HEIGHT_L);
   assign at_last   = (x == x_last) && (y == y_last);

   assign busy_o = (state == RUN);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // The engine is silenced in the reset cycle itself so a mid-fill reset issues no further writes.
   always_comb begin
      state_nxt = state;
      fill_we   = 1'b0;
      launch    = 1'b0;
      reject    = 1'b0;
      finish    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_req) begin
               if (params_ok) begin
                  launch    = 1'b1;
                  state_nxt = RUN;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         RUN: begin
            fill_we = !cpu_we_i && !rst_i;
            if (abort_req) begin
               state_nxt = IDLE;
            end else if (fill_we && at_last) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      vmem_we_o    = cpu_we_i || fill_we;
      vmem_waddr_o = '0;
      vmem_wdata_o = '0;
      if (cpu_we_i) begin
         vmem_waddr_o = cpu_waddr_i;
         vmem_wdata_o = cpu_wdata_i;
      end else if (fill_we) begin
         vmem_waddr_o = {y, x};
         vmem_wdata_o = color;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x0          <= '0;
         y0          <= '0;
         w           <= '0;
         h           <= '0;
         color       <= '0;
         x           <= '0;
         y           <= '0;
         done_flag   <= 1'b0;
         err_flag    <= 1'b0;
         done_o      <= 1'b0;
         cfg_rdata_o <= '0;
      end else begin
         done_o <= finish;
         if (launch) begin
            err_flag  <= 1'b0;
            done_flag <= 1'b0;
            x         <= x0;
            y         <= y0;
         end
         if (reject) begin
            err_flag  <= 1'b1;
            done_flag <= 1'b0;
         end
         if (finish) done_flag <= 1'b1;
         if (fill_we) begin
            if (x == x_last) begin
               x <= x0;
               y <= y + 8'd1;
            end else begin
               x <= x + 8'd1;
            end
         end
         if (cfg_we_i && state == IDLE) begin
            unique case (cfg_addr_i[3:2])
               2'd1: begin
                  x0 <= cfg_wdata_i[7:0];
                  y0 <= cfg_wdata_i[15:8];
               end
               2'd2: begin
                  w <= cfg_wdata_i[7:0];
                  h <= cfg_wdata_i[15:8];
               end
               2'd3:    color <= cfg_wdata_i[2:0];
               default: ;
            endcase
         end
         unique case (cfg_addr_i[3:2])
            2'd0: cfg_rdata_o <= {29'd0, err_flag, done_flag, busy_o};
            2'd1: cfg_rdata_o <= {16'd0, y0, x0};
            2'd2: cfg_rdata_o <= {16'd0, h, w};
            2'd3: cfg_rdata_o <= {29'd0, color};
            default: cfg_rdata_o <= '0;
         endcase
      end
   end

endmodule
